// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the byte-addressed data memory.
//   - Access mode encodings (bit 2 = unsigned, used on loads only).
//   - Size field helper, also meant for reuse by the load/store unit.
//   - Lane-mask helper: which of the 4 byte lanes a store touches.
package dmem_pkg;

    localparam logic [2:0] MODE_W  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_HU = 3'b101;
    localparam logic [2:0] MODE_B  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b110;

    typedef enum logic [1:0] {
        SIZE_W   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_B   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    // Size field only; does not reject reserved modes such as 3'b100.
    function automatic size_e mode_size(input logic [2:0] mode);
        return size_e'(mode[1:0]);
    endfunction

    function automatic logic mode_valid(input logic [2:0] mode);
        logic ok;
        case (mode)
            MODE_W, MODE_H, MODE_HU, MODE_B, MODE_BU: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes (relative to addr) written by a store in this mode.
    // Reserved modes write nothing, including 3'b100 whose size field
    // alone would look like a word.
    function automatic logic [3:0] lane_mask(input logic [2:0] mode);
        logic [3:0] m;
        m = 4'b0000;
        if (mode_valid(mode)) begin
            case (mode_size(mode))
                SIZE_W:  m = 4'b1111;
                SIZE_H:  m = 4'b0011;
                SIZE_B:  m = 4'b0001;
                default: m = 4'b0000;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: sizes and extends the four gathered load bytes.
// Ports:
//   mode_i  [2:0]  access mode
//   bytes_i [31:0] bytes addr..addr+3, little-endian (addr in [7:0])
//   data_o  [31:0] load result; zero for reserved modes
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [31:0] bytes_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (mode_i)
            MODE_W:  data_o = bytes_i;
            MODE_H:  data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            MODE_HU: data_o = {16'h0000, bytes_i[15:0]};
            MODE_B:  data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
            MODE_BU: data_o = {24'h000000, bytes_i[7:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian data memory for load/store.
// Combinational reads, writes on rising clk, synchronous reset clears all.
// Ports:
//   clk             system clock
//   reset           synchronous active-high; zeroes every byte, beats we
//   we              store enable
//   mode      [2:0] access size / extension (see dmem_pkg)
//   addr     [31:0] byte address; only addr[AW-1:0] is used
//   writedata[31:0] store data, low bytes for sub-word stores
//   readdata [31:0] load data, sized and extended by mode
// DEPTH must be a power of two and at least 4, so the four lanes of a
// wrapping access always land on distinct bytes.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [2:0]  mode,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    // Register array rather than block RAM: reset must clear every byte
    // and reads are asynchronous.
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];

    logic [AW-1:0] lane_idx  [4];
    logic [7:0]    lane_data [4];
    logic [3:0]    lane_wr;
    logic [31:0]   rd_bytes;

    // Address bits above AW are ignored by design (modulo DEPTH).
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW];

    // Lane k addresses byte (addr + k) mod DEPTH; the AW-bit add wraps.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        assign lane_idx[gi]          = addr[AW-1:0] + AW'(gi);
        assign lane_data[gi]         = writedata[8*gi +: 8];
        assign rd_bytes[8*gi +: 8]   = mem_q[lane_idx[gi]];
    end

    assign lane_wr = we ? lane_mask(mode) : 4'b0000;

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < 4; k++) begin
            if (lane_wr[k]) begin
                mem_d[lane_idx[k]] = lane_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    dmem_load_ext u_load_ext (
        .mode_i  (mode),
        .bytes_i (rd_bytes),
        .data_o  (readdata)
    );

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    localparam int DEPTH = 256;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_WR  = 2'd1;
    localparam logic [1:0] OP_RD  = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs [64];
    int   n_vecs = 0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .mode      (mode),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata)
    );

    task automatic check(input string name, input logic [31:0] exp);
        n_checks++;
        if (readdata === exp) begin
            n_pass++;
            $display("chk %-14s mode=%03b addr=%08h read=%08h ok", name, mode, addr, readdata);
        end else begin
            $display("FAIL %s: mode=%03b addr=%08h got %08h, required %08h",
                     name, mode, addr, readdata, exp);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        vecs[n_vecs] = '{op: op, mode: m, addr: a, wdata: d, exp: e};
        n_vecs++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        $display("rst");
    endtask

    task automatic do_write(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset     = 1'b0;
        we        = 1'b1;
        mode      = m;
        addr      = a;
        writedata = d;
        @(posedge clk);
        #1 we = 1'b0;
        $display("wr  mode=%03b addr=%08h data=%08h", m, a, d);
    endtask

    task automatic do_read(input string name, input logic [2:0] m,
                           input logic [31:0] a, input logic [31:0] e);
        @(negedge clk);
        we   = 1'b0;
        mode = m;
        addr = a;
        #1 check(name, e);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            case (vecs[i].op)
                OP_RST:  do_reset();
                OP_WR:   do_write(vecs[i].mode, vecs[i].addr, vecs[i].wdata);
                default: do_read($sformatf("vec%0d", i), vecs[i].mode, vecs[i].addr, vecs[i].exp);
            endcase
        end
    endtask

    int split;

    initial begin
        reset     = 1'b1;
        we        = 1'b0;
        mode      = 3'b000;
        addr      = '0;
        writedata = '0;

        // Part 1: reset state, word store, unaligned halfword, byte stores.
        add(OP_RST, 3'b000, 32'd0,  32'h0, 32'h0);
        add(OP_RD,  3'b000, 32'd4,  32'h0, 32'h0000_0000);
        add(OP_RD,  3'b001, 32'd7,  32'h0, 32'h0000_0000);
        add(OP_RD,  3'b110, 32'd200,32'h0, 32'h0000_0000);
        add(OP_WR,  3'b000, 32'd4,  32'hF00A_A00F, 32'h0);
        add(OP_RD,  3'b000, 32'd4,  32'h0, 32'hF00A_A00F);
        add(OP_RD,  3'b001, 32'd4,  32'h0, 32'hFFFF_A00F);
        add(OP_RD,  3'b101, 32'd4,  32'h0, 32'h0000_A00F);
        add(OP_RD,  3'b010, 32'd4,  32'h0, 32'h0000_000F);
        add(OP_RD,  3'b010, 32'd7,  32'h0, 32'hFFFF_FFF0);
        add(OP_RD,  3'b110, 32'd7,  32'h0, 32'h0000_00F0);
        add(OP_WR,  3'b001, 32'd5,  32'hFFFF_FFFF, 32'h0);
        add(OP_RD,  3'b000, 32'd4,  32'h0, 32'hF0FF_FF0F);
        add(OP_RD,  3'b001, 32'd5,  32'h0, 32'hFFFF_FFFF);
        add(OP_RD,  3'b101, 32'd5,  32'h0, 32'h0000_FFFF);
        add(OP_WR,  3'b010, 32'd10, 32'h0000_00AA, 32'h0);
        add(OP_WR,  3'b010, 32'd11, 32'h0000_00BB, 32'h0);
        add(OP_WR,  3'b010, 32'd12, 32'h0000_BBAA, 32'h0);
        add(OP_RD,  3'b000, 32'd8,  32'h0, 32'hBBAA_0000);
        add(OP_RD,  3'b000, 32'd12, 32'h0, 32'h0000_00AA);
        add(OP_RD,  3'b001, 32'd10, 32'h0, 32'hFFFF_BBAA);
        split = n_vecs;

        // Part 2: wrap-around and reserved modes.
        add(OP_WR,  3'b000, DEPTH - 1, 32'h1122_3344, 32'h0);
        add(OP_RD,  3'b110, DEPTH - 1, 32'h0, 32'h0000_0044);
        add(OP_RD,  3'b000, 32'd0,  32'h0, 32'h0011_2233);
        add(OP_RD,  3'b000, 32'hFFFF_FFFF, 32'h0, 32'h1122_3344);
        add(OP_RD,  3'b110, 32'hFFFF_FFFF, 32'h0, 32'h0000_0044);
        add(OP_RD,  3'b001, 32'hFFFF_FFFF, 32'h0, 32'h0000_3344);
        add(OP_WR,  3'b000, 32'd4,  32'hCAFE_F00D, 32'h0);
        add(OP_WR,  3'b011, 32'd4,  32'hDEAD_BEEF, 32'h0);
        add(OP_WR,  3'b100, 32'd4,  32'hDEAD_BEEF, 32'h0);
        add(OP_WR,  3'b111, 32'd4,  32'hDEAD_BEEF, 32'h0);
        add(OP_RD,  3'b000, 32'd4,  32'h0, 32'hCAFE_F00D);
        add(OP_RD,  3'b011, 32'd4,  32'h0, 32'h0000_0000);
        add(OP_RD,  3'b100, 32'd4,  32'h0, 32'h0000_0000);
        add(OP_RD,  3'b111, 32'd4,  32'h0, 32'h0000_0000);

        run_vecs(0, split);

        // Reset beats a simultaneous write; old data visible until the edge.
        @(negedge clk);
        reset     = 1'b1;
        we        = 1'b1;
        mode      = 3'b000;
        addr      = 32'd4;
        writedata = 32'h1234_5678;
        #1 check("rst_pre_w4", 32'hF0FF_FF0F);
        addr = 32'd8;
        #1 check("rst_pre_w8", 32'hBBAA_0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        we    = 1'b0;
        $display("rst+wr addr=00000008 data=12345678");
        do_read("rst_w4",  3'b000, 32'd4,  32'h0);
        do_read("rst_w8",  3'b000, 32'd8,  32'h0);
        do_read("rst_w12", 3'b000, 32'd12, 32'h0);

        run_vecs(split, n_vecs);

        // Read-during-write: no bypass before the edge, new data right after.
        @(negedge clk);
        we        = 1'b1;
        mode      = 3'b000;
        addr      = 32'd20;
        writedata = 32'h5566_7788;
        #1 check("rdw_before", 32'h0000_0000);
        @(posedge clk);
        #1 check("rdw_after", 32'h5566_7788);
        we = 1'b0;
        $display("wr  mode=000 addr=00000014 data=55667788 (read-during-write)");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
